// File: rtl/pcs_block_lock_ber_if.sv
// Gearbox-to-block-sync bundle: sync headers in, slip/lock/BER status out.
// master drives the gearbox side, slave is the block-lock unit.
interface pcs_block_lock_ber_if;
  logic [1:0]  i_header;
  logic        i_valid;
  logic        i_header_valid;
  logic        o_slip;
  logic        o_block_lock;
  logic        o_hi_ber;
  logic [15:0] o_err_count;

  modport master (
    output i_header,
    output i_valid,
    output i_header_valid,
    input  o_slip,
    input  o_block_lock,
    input  o_hi_ber,
    input  o_err_count
  );

  modport slave (
    input  i_header,
    input  i_valid,
    input  i_header_valid,
    output o_slip,
    output o_block_lock,
    output o_hi_ber,
    output o_err_count
  );
endinterface

// File: rtl/pcs_block_lock_ber.sv
// 10GBASE-R RX block lock with slip control and windowed lock tolerance.
// Optional high-BER monitor enabled by defining PCS_BER_MONITOR_EN.
module pcs_block_lock_ber #(
  parameter int DATA_WIDTH        = 32,
  parameter int SH_CNT_MAX        = 64,
  parameter int SH_INVALID_MAX    = 16,
  parameter int SLIP_WAIT         = 32,
  parameter int BER_WINDOW_CYCLES = 39062,
  parameter int BER_BAD_MAX       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pcs_block_lock_ber_if.slave  bus
);

  localparam int SW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVALID_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam bit W64 = (DATA_WIDTH == 64);

  localparam logic [SW-1:0] SH_LAST  = SW'(SH_CNT_MAX - 1);
  localparam logic [IW-1:0] INV_LAST = IW'(SH_INVALID_MAX - 1);
  localparam logic [WW-1:0] WT_LAST  = WW'(SLIP_WAIT - 1);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) ||
      SH_CNT_MAX < 1 || SH_INVALID_MAX < 1 ||
      SLIP_WAIT < 1 || BER_WINDOW_CYCLES < 2 ||
      BER_BAD_MAX < 1) begin : g_bad_cfg
    $error("pcs_block_lock_ber: unsupported parameters");
  end

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_SLIP_WAIT,
    ST_LOCKED
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [SW-1:0]   sh_cnt;
  logic [SW-1:0]   sh_n;
  logic [IW-1:0]   inv_cnt;
  logic [IW-1:0]   inv_n;
  logic [WW-1:0]   wait_cnt;
  logic [WW-1:0]   wait_n;
  logic            slip_q;
  logic            slip_n;
  logic            lock_q;
  logic            lock_n;
  logic [15:0]     err_cnt;
  logic            hdr_ev;
  logic            sh_bad;

  // 64-bit beats always carry a header; 32-bit beats flag it
  assign hdr_ev = bus.i_valid & (W64 | bus.i_header_valid);
  assign sh_bad = ~(bus.i_header[1] ^ bus.i_header[0]);

  always_comb begin
    state_n = state;
    sh_n    = sh_cnt;
    inv_n   = inv_cnt;
    wait_n  = wait_cnt;
    slip_n  = 1'b0;
    lock_n  = lock_q;
    unique case (state)
      ST_UNLOCKED: begin
        if (hdr_ev) begin
          if (sh_bad) begin
            slip_n  = 1'b1;
            sh_n    = '0;
            wait_n  = '0;
            state_n = ST_SLIP_WAIT;
          end else if (sh_cnt == SH_LAST) begin
            sh_n    = '0;
            inv_n   = '0;
            lock_n  = 1'b1;
            state_n = ST_LOCKED;
          end else begin
            sh_n = sh_cnt + 1'b1;
          end
        end
      end
      ST_SLIP_WAIT: begin
        if (bus.i_valid) begin
          if (wait_cnt == WT_LAST) begin
            wait_n  = '0;
            sh_n    = '0;
            inv_n   = '0;
            state_n = ST_UNLOCKED;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (hdr_ev) begin
          // loss of lock wins over the window restart on the same header
          if (sh_bad && inv_cnt == INV_LAST) begin
            lock_n  = 1'b0;
            slip_n  = 1'b1;
            sh_n    = '0;
            inv_n   = '0;
            wait_n  = '0;
            state_n = ST_SLIP_WAIT;
          end else if (sh_cnt == SH_LAST) begin
            sh_n  = '0;
            inv_n = '0;
          end else begin
            sh_n  = sh_cnt + 1'b1;
            inv_n = inv_cnt + IW'(sh_bad);
          end
        end
      end
      default: begin
        state_n = ST_UNLOCKED;
        sh_n    = '0;
        inv_n   = '0;
        wait_n  = '0;
        lock_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_UNLOCKED;
      sh_cnt   <= '0;
      inv_cnt  <= '0;
      wait_cnt <= '0;
      slip_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sh_cnt   <= sh_n;
      inv_cnt  <= inv_n;
      wait_cnt <= wait_n;
      slip_q   <= slip_n;
      lock_q   <= lock_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_cnt <= '0;
    end else if (hdr_ev && sh_bad && lock_q &&
                 err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.o_slip       = slip_q;
  assign bus.o_block_lock = lock_q;
  assign bus.o_err_count  = err_cnt;

`ifdef PCS_BER_MONITOR_EN
  localparam int BWW = $clog2(BER_WINDOW_CYCLES);
  localparam int BCW = $clog2(BER_BAD_MAX + 1);
  localparam logic [BWW-1:0] WIN_LAST = BWW'(BER_WINDOW_CYCLES - 1);
  localparam logic [BCW-1:0] BAD_MAX  = BCW'(BER_BAD_MAX);

  logic [BWW-1:0] win_cnt;
  logic [BCW-1:0] ber_cnt;
  logic [BCW-1:0] ber_n;
  logic           hi_ber_q;
  logic           hi_n;
  logic           ber_inv;
  logic           win_wrap;

  assign ber_inv  = hdr_ev & sh_bad & lock_q;
  assign win_wrap = (win_cnt == WIN_LAST);

  // a bad header on the wrap cycle opens the new window
  always_comb begin
    ber_n = ber_cnt;
    hi_n  = hi_ber_q;
    if (win_wrap) begin
      ber_n = BCW'(ber_inv);
      if (ber_cnt < BAD_MAX)
        hi_n = 1'b0;
    end else if (ber_inv && ber_cnt != BAD_MAX) begin
      ber_n = ber_cnt + 1'b1;
    end
    if (ber_n == BAD_MAX)
      hi_n = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !lock_q || !lock_n) begin
      win_cnt  <= '0;
      ber_cnt  <= '0;
      hi_ber_q <= 1'b0;
    end else begin
      win_cnt  <= win_wrap ? '0 : win_cnt + 1'b1;
      ber_cnt  <= ber_n;
      hi_ber_q <= hi_n;
    end
  end

  assign bus.o_hi_ber = hi_ber_q;
`else
  assign bus.o_hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_block_lock_ber.sv
// Randomized bench for pcs_block_lock_ber (64- and 32-bit instances)
// checked each cycle against a rule-level reference model.
module tb_pcs_block_lock_ber;

  localparam int SHN   = 64;
  localparam int INVN  = 16;
  localparam int WAITN = 32;
  localparam int BERW  = 200;
  localparam int BADN  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int errors  = 0;

  // model: mode 0 hunting, 1 waiting after slip, 2 locked
  int m_mode[2];
  int m_sh[2];
  int m_inv[2];
  int m_wt[2];
  int m_slip[2];
  int m_lock[2];
  int m_err[2];
  int m_win[2];
  int m_ber[2];
  int m_hib[2];

  always #5 clk = ~clk;

  pcs_block_lock_ber_if b64();
  pcs_block_lock_ber_if b32();

  pcs_block_lock_ber #(
    .DATA_WIDTH(64),
    .SH_CNT_MAX(SHN),
    .SH_INVALID_MAX(INVN),
    .SLIP_WAIT(WAITN),
    .BER_WINDOW_CYCLES(BERW),
    .BER_BAD_MAX(BADN)
  ) dut64 (
    .i_clk(clk),
    .i_reset(rst),
    .bus(b64)
  );

  pcs_block_lock_ber #(
    .DATA_WIDTH(32),
    .SH_CNT_MAX(SHN),
    .SH_INVALID_MAX(INVN),
    .SLIP_WAIT(WAITN),
    .BER_WINDOW_CYCLES(BERW),
    .BER_BAD_MAX(BADN)
  ) dut32 (
    .i_clk(clk),
    .i_reset(rst),
    .bus(b32)
  );

  function automatic logic [1:0] good_h();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_h();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_step(input int d, input logic rs,
                            input logic [1:0] h, input logic v,
                            input logic hv);
    bit ev;
    bit bad;
    int ol;
    if (rs) begin
      m_mode[d] = 0; m_sh[d] = 0; m_inv[d] = 0; m_wt[d] = 0;
      m_slip[d] = 0; m_lock[d] = 0; m_err[d] = 0;
      m_win[d] = 0; m_ber[d] = 0; m_hib[d] = 0;
      return;
    end
    ev  = v && (d == 0 || hv);
    bad = (h == 2'b00 || h == 2'b11);
    ol  = m_lock[d];
    m_slip[d] = 0;
    if (ev && bad && ol != 0 && m_err[d] < 65535)
      m_err[d]++;
`ifdef PCS_BER_MONITOR_EN
    if (ol != 0) begin
      if (m_win[d] == BERW - 1) begin
        m_win[d] = 0;
        if (m_ber[d] < BADN) m_hib[d] = 0;
        m_ber[d] = (ev && bad) ? 1 : 0;
      end else begin
        m_win[d]++;
        if (ev && bad && m_ber[d] < BADN) m_ber[d]++;
      end
      if (m_ber[d] >= BADN) m_hib[d] = 1;
    end
`endif
    case (m_mode[d])
      0: if (ev) begin
        if (bad) begin
          m_slip[d] = 1; m_mode[d] = 1; m_wt[d] = 0; m_sh[d] = 0;
        end else begin
          m_sh[d]++;
          if (m_sh[d] == SHN) begin
            m_mode[d] = 2; m_lock[d] = 1; m_sh[d] = 0; m_inv[d] = 0;
          end
        end
      end
      1: if (v) begin
        m_wt[d]++;
        if (m_wt[d] == WAITN) begin
          m_mode[d] = 0; m_wt[d] = 0; m_sh[d] = 0;
        end
      end
      default: if (ev) begin
        m_sh[d]++;
        if (bad) m_inv[d]++;
        if (m_inv[d] == INVN) begin
          m_lock[d] = 0; m_slip[d] = 1; m_mode[d] = 1;
          m_wt[d] = 0; m_sh[d] = 0; m_inv[d] = 0;
        end else if (m_sh[d] == SHN) begin
          m_sh[d] = 0; m_inv[d] = 0;
        end
      end
    endcase
    if (m_lock[d] == 0) begin
      m_win[d] = 0; m_ber[d] = 0; m_hib[d] = 0;
    end
  endtask

  task automatic tick(input logic rs,
                      input logic [1:0] h0, input logic v0,
                      input logic [1:0] h1, input logic v1,
                      input logic hv1);
    rst = rs;
    b64.i_header = h0;
    b64.i_valid = v0;
    b64.i_header_valid = 1'($urandom_range(0, 1));
    b32.i_header = h1;
    b32.i_valid = v1;
    b32.i_header_valid = hv1;
    @(posedge clk);
    model_step(0, rs, h0, v0, b64.i_header_valid);
    model_step(1, rs, h1, v1, hv1);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 2'($urandom), 1'b1, 2'($urandom), 1'b1, 1'b1);
      vectors++;
      if ({b64.o_slip, b64.o_block_lock, b64.o_hi_ber} !== 3'b000 ||
          b64.o_err_count !== 16'd0) begin
        errors++;
        $display("FAIL reset64: got %b%b%b/%0d want 000/0",
                 b64.o_slip, b64.o_block_lock, b64.o_hi_ber,
                 b64.o_err_count);
      end
      vectors++;
      if ({b32.o_slip, b32.o_block_lock, b32.o_hi_ber} !== 3'b000 ||
          b32.o_err_count !== 16'd0) begin
        errors++;
        $display("FAIL reset32: got %b%b%b/%0d want 000/0",
                 b32.o_slip, b32.o_block_lock, b32.o_hi_ber,
                 b32.o_err_count);
      end
    end
  endtask

  task automatic test_slip();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, good_h(), 1'b1, 2'b00, 1'b0, 1'b0);
      vectors++;
      if (b64.o_slip !== 1'b0 || b64.o_block_lock !== 1'b0) begin
        errors++;
        $display("FAIL slip_pre: slip/lock got %b%b want 00",
                 b64.o_slip, b64.o_block_lock);
      end
    end
    tick(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
    vectors++;
    if (b64.o_slip !== 1'b1) begin
      errors++;
      $display("FAIL slip_pulse: slip got %b want 1", b64.o_slip);
    end
    for (int n = 0; n < WAITN; ) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      tick(1'b0, 2'b00, v, 2'b00, 1'b0, 1'b0);
      if (v) n++;
      vectors++;
      if (b64.o_slip !== 1'b0 || b64.o_slip !== 1'(m_slip[0])) begin
        errors++;
        $display("FAIL slip_wait: slip got %b want 0 (beat %0d)",
                 b64.o_slip, n);
      end
    end
    tick(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    vectors++;
    if (b64.o_slip !== 1'b1) begin
      errors++;
      $display("FAIL slip_resume: slip got %b want 1", b64.o_slip);
    end
    for (int i = 0; i < WAITN; i++) begin
      tick(1'b0, good_h(), 1'b1, 2'b00, 1'b0, 1'b0);
      vectors++;
      if (b64.o_slip !== 1'(m_slip[0]) ||
          b64.o_block_lock !== 1'(m_lock[0])) begin
        errors++;
        $display("FAIL slip_exit: slip/lock got %b%b want %0d%0d",
                 b64.o_slip, b64.o_block_lock, m_slip[0], m_lock[0]);
      end
    end
  endtask

  task automatic test_lock64();
    for (int i = 0; i < SHN; i++) begin
      tick(1'b0, good_h(), 1'b1, 2'b00, 1'b0, 1'b0);
      vectors++;
      if (b64.o_block_lock !== (i == SHN - 1) || b64.o_slip !== 1'b0 ||
          b64.o_block_lock !== 1'(m_lock[0])) begin
        errors++;
        $display("FAIL lock64 hdr %0d: slip/lock got %b%b want 0%b",
                 i + 1, b64.o_slip, b64.o_block_lock, i == SHN - 1);
      end
    end
  endtask

  task automatic test_locked_errors();
    int rb;
    int rs;
    rb = 15;
    rs = SHN;
    while (rs > 0) begin
      logic stall;
      logic isbad;
      stall = ($urandom_range(0, 3) == 0);
      isbad = !stall && ($urandom_range(0, rs - 1) < rb);
      if (stall) tick(1'b0, 2'($urandom), 1'b0, 2'b00, 1'b0, 1'b0);
      else tick(1'b0, isbad ? bad_h() : good_h(), 1'b1,
                2'b00, 1'b0, 1'b0);
      if (!stall) rs--;
      if (isbad) rb--;
      vectors++;
      if (b64.o_block_lock !== 1'b1 || b64.o_slip !== 1'b0 ||
          b64.o_err_count !== 16'(15 - rb) ||
          b64.o_hi_ber !== 1'(m_hib[0])) begin
        errors++;
        $display("FAIL win15: lock/slip/err got %b%b/%0d want 10/%0d",
                 b64.o_block_lock, b64.o_slip, b64.o_err_count, 15 - rb);
      end
    end
    rb = INVN;
    rs = SHN;
    while (rb > 0) begin
      logic stall;
      logic isbad;
      stall = ($urandom_range(0, 3) == 0);
      isbad = !stall && ($urandom_range(0, rs - 1) < rb);
      if (stall) tick(1'b0, 2'($urandom), 1'b0, 2'b00, 1'b0, 1'b0);
      else tick(1'b0, isbad ? bad_h() : good_h(), 1'b1,
                2'b00, 1'b0, 1'b0);
      if (!stall) rs--;
      if (isbad) rb--;
      vectors++;
      if (b64.o_block_lock !== (rb != 0) || b64.o_slip !== (rb == 0) ||
          b64.o_err_count !== 16'(15 + INVN - rb)) begin
        errors++;
        $display("FAIL win16: lock/slip/err got %b%b/%0d want %b%b/%0d",
                 b64.o_block_lock, b64.o_slip, b64.o_err_count,
                 rb != 0, rb == 0, 15 + INVN - rb);
      end
    end
    for (int i = 0; i < WAITN + 4; i++) begin
      tick(1'b0, 2'($urandom), 1'b1, 2'b00, 1'b0, 1'b0);
      vectors++;
      if (b64.o_slip !== 1'(m_slip[0]) ||
          b64.o_block_lock !== 1'(m_lock[0]) ||
          b64.o_err_count !== 16'(m_err[0])) begin
        errors++;
        $display("FAIL post_loss: slip/lock/err got %b%b/%0d want %0d%0d/%0d",
                 b64.o_slip, b64.o_block_lock, b64.o_err_count,
                 m_slip[0], m_lock[0], m_err[0]);
      end
    end
  endtask

  task automatic test_width32();
    int ev;
    ev = 0;
    for (int i = 0; i < 4000 && ev < SHN; i++) begin
      logic v;
      logic hv;
      v  = ($urandom_range(0, 3) != 0);
      hv = 1'($urandom_range(0, 1));
      tick(1'b0, 2'b00, 1'b0, hv ? good_h() : 2'b11, v, hv);
      if (v && hv) ev++;
      vectors++;
      if (b32.o_block_lock !== (ev == SHN) || b32.o_slip !== 1'b0 ||
          b32.o_block_lock !== 1'(m_lock[1])) begin
        errors++;
        $display("FAIL width32 ev %0d: slip/lock got %b%b want 0%b",
                 ev, b32.o_slip, b32.o_block_lock, ev == SHN);
      end
    end
    vectors++;
    if (ev != SHN) begin
      errors++;
      $display("FAIL width32_budget: events %0d want %0d", ev, SHN);
    end
  endtask

  task automatic test_ber();
    tick(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < SHN; i++)
      tick(1'b0, good_h(), 1'b1, 2'b00, 1'b0, 1'b0);
    for (int c = 0; c < 546; c++) begin
      logic isbad;
      isbad = ((c < 32 || (c >= 64 && c < 96) ||
                (c >= 448 && c < 480) || (c >= 512 && c < 544)) &&
               c % 4 == 0) || c == 210 || c == 220 || c == 230;
      tick(1'b0, isbad ? bad_h() : good_h(), 1'b1, 2'b00, 1'b0, 1'b0);
      vectors++;
      if (b64.o_hi_ber !== 1'(m_hib[0]) || b64.o_block_lock !== 1'b1 ||
          b64.o_err_count !== 16'(m_err[0])) begin
        errors++;
        $display("FAIL ber c=%0d: hiber/lock/err got %b%b/%0d want %0d1/%0d",
                 c, b64.o_hi_ber, b64.o_block_lock, b64.o_err_count,
                 m_hib[0], m_err[0]);
      end
`ifdef PCS_BER_MONITOR_EN
      if (c == 92 || c == 398 || c == 399 || c == 540) begin
        vectors++;
        if (b64.o_hi_ber !== (c != 399)) begin
          errors++;
          $display("FAIL ber_mark c=%0d: hiber got %b want %b",
                   c, b64.o_hi_ber, c != 399);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, good_h(), 1'b1, 2'b00, 1'b0, 1'b0);
    vectors++;
    if ({b64.o_slip, b64.o_block_lock, b64.o_hi_ber} !== 3'b000 ||
        b64.o_err_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_locked: got %b%b%b/%0d want 000/0",
               b64.o_slip, b64.o_block_lock, b64.o_hi_ber,
               b64.o_err_count);
    end
    tick(1'b0, bad_h(), 1'b1, 2'b00, 1'b0, 1'b0);
    vectors++;
    if (b64.o_slip !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_slip: slip got %b want 1", b64.o_slip);
    end
    for (int i = 0; i < 5; i++)
      tick(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    vectors++;
    if ({b64.o_slip, b64.o_block_lock, b64.o_hi_ber} !== 3'b000 ||
        b64.o_err_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_wait: got %b%b%b/%0d want 000/0",
               b64.o_slip, b64.o_block_lock, b64.o_hi_ber,
               b64.o_err_count);
    end
    for (int i = 0; i < SHN; i++) begin
      tick(1'b0, good_h(), 1'b1, 2'b00, 1'b0, 1'b0);
      vectors++;
      if (b64.o_block_lock !== (i == SHN - 1) || b64.o_slip !== 1'b0) begin
        errors++;
        $display("FAIL relock hdr %0d: slip/lock got %b%b want 0%b",
                 i + 1, b64.o_slip, b64.o_block_lock, i == SHN - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slip();
    test_lock64();
    test_locked_errors();
    test_width32();
    test_ber();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
